// File: rtl/ssd_mux_rx_pkg.sv
// Shared definitions for the multiplexed 7-segment receiver: glyph encodings,
// FSM states and the decoder result type.
package ssd_mux_rx_pkg;

  // Segment bit order: {A,B,C,D,E,F,G}, bit 6 = A
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SSD_GLYPH_0 = 7'h7E;
  localparam logic [SEG_W-1:0] SSD_GLYPH_1 = 7'h30;
  localparam logic [SEG_W-1:0] SSD_GLYPH_2 = 7'h6D;
  localparam logic [SEG_W-1:0] SSD_GLYPH_3 = 7'h79;
  localparam logic [SEG_W-1:0] SSD_GLYPH_4 = 7'h33;
  localparam logic [SEG_W-1:0] SSD_GLYPH_5 = 7'h5B;
  localparam logic [SEG_W-1:0] SSD_GLYPH_6 = 7'h5F;
  localparam logic [SEG_W-1:0] SSD_GLYPH_7 = 7'h70;
  localparam logic [SEG_W-1:0] SSD_GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SSD_GLYPH_9 = 7'h73;
  localparam logic [SEG_W-1:0] SSD_GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] SSD_GLYPH_B = 7'h1F;
  localparam logic [SEG_W-1:0] SSD_GLYPH_C = 7'h4E;
  localparam logic [SEG_W-1:0] SSD_GLYPH_D = 7'h3D;
  localparam logic [SEG_W-1:0] SSD_GLYPH_E = 7'h4F;
  localparam logic [SEG_W-1:0] SSD_GLYPH_F = 7'h47;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_SAMPLE    = 2'd2,
    ST_WAIT_EDGE = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] nib;
  } glyph_dec_t;

  // Counter width for a count range 0..n-1, never zero bits wide
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssd_mux_rx_if.sv
// Receiver-side bundle: the sampled display bus plus the reassembled value/status.
interface ssd_mux_rx_if;
  logic [6:0] seg_in;
  logic       sel_in;
  logic [7:0] value;
  logic       value_valid;
  logic       frame_stb;
  logic       bad_glyph;
  logic       link_lost;

  // master drives the display bus and observes the result
  modport master (
    output seg_in, sel_in,
    input  value, value_valid, frame_stb, bad_glyph, link_lost
  );

  modport slave (
    input  seg_in, sel_in,
    output value, value_valid, frame_stb, bad_glyph, link_lost
  );
endinterface

// File: rtl/ssd_mux_rx_glyph_decode.sv
// Combinational 7-segment glyph -> hex nibble decoder; anything outside the
// sixteen known glyphs (including blank) is flagged illegal.
module ssd_mux_rx_glyph_decode
  import ssd_mux_rx_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output glyph_dec_t       dec
);

  always_comb begin
    dec.legal = 1'b1;
    dec.nib   = 4'h0;
    case (seg)
      SSD_GLYPH_0: dec.nib = 4'h0;
      SSD_GLYPH_1: dec.nib = 4'h1;
      SSD_GLYPH_2: dec.nib = 4'h2;
      SSD_GLYPH_3: dec.nib = 4'h3;
      SSD_GLYPH_4: dec.nib = 4'h4;
      SSD_GLYPH_5: dec.nib = 4'h5;
      SSD_GLYPH_6: dec.nib = 4'h6;
      SSD_GLYPH_7: dec.nib = 4'h7;
      SSD_GLYPH_8: dec.nib = 4'h8;
      SSD_GLYPH_9: dec.nib = 4'h9;
      SSD_GLYPH_A: dec.nib = 4'hA;
      SSD_GLYPH_B: dec.nib = 4'hB;
      SSD_GLYPH_C: dec.nib = 4'hC;
      SSD_GLYPH_D: dec.nib = 4'hD;
      SSD_GLYPH_E: dec.nib = 4'hE;
      SSD_GLYPH_F: dec.nib = 4'hF;
      default:     dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_mux_rx.sv
// Loopback receiver for the 2-digit multiplexed 7-segment bus: samples each digit
// after a settle delay, reassembles {hi,lo} and publishes it once stable.
// Define SSD_RX_SEG_ACTIVE_LOW_EN for a common-anode (active-low) segment bus.
module ssd_mux_rx
  import ssd_mux_rx_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 4_000_000,
  parameter int STABLE_FRAMES  = 2
) (
  input logic         clk,
  input logic         nrst,
  ssd_mux_rx_if.slave bus
);

  localparam int SW  = cnt_w(SETTLE_CYCLES);
  localparam int TW  = cnt_w(TIMEOUT_CYCLES);
  localparam int STW = cnt_w(STABLE_FRAMES + 1);
  localparam logic [SW-1:0]  SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [STW-1:0] STABLE_MAX   = STW'(STABLE_FRAMES);

  // ---- input synchronizers and sel edge detect
  logic [1:0][SEG_W-1:0] seg_sync;
  logic [1:0]            sel_sync;
  logic                  sel_q;
  logic                  sel_edge;
  logic [SEG_W-1:0]      seg_use;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seg_sync <= '0;
      sel_sync <= '0;
      sel_q    <= 1'b0;
    end else begin
      seg_sync <= {seg_sync[0], bus.seg_in};
      sel_sync <= {sel_sync[0], bus.sel_in};
      sel_q    <= sel_sync[1];
    end
  end

  assign sel_edge = sel_sync[1] ^ sel_q;

`ifdef SSD_RX_SEG_ACTIVE_LOW_EN
  assign seg_use = ~seg_sync[1];
`else
  assign seg_use = seg_sync[1];
`endif

  glyph_dec_t dec;

  ssd_mux_rx_glyph_decode u_dec (
    .seg (seg_use),
    .dec (dec)
  );

  // ---- FSM
  rx_state_t      state, state_nxt;
  logic [SW-1:0]  scnt;
  logic [TW-1:0]  tcnt;
  logic           settle_done, tmo_hit, sample_en;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // An edge always wins: it restarts settling and reloads the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (sel_edge) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if      (sel_edge)    state_nxt = ST_SETTLE;
        else if (tmo_hit)     state_nxt = ST_IDLE;
        else if (settle_done) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE:    state_nxt = sel_edge ? ST_SETTLE : ST_WAIT_EDGE;
      ST_WAIT_EDGE: begin
        if      (sel_edge) state_nxt = ST_SETTLE;
        else if (tmo_hit)  state_nxt = ST_IDLE;
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    settle_done = 1'b0;
    tmo_hit     = 1'b0;
    sample_en   = 1'b0;
    case (state)
      ST_SETTLE: begin
        settle_done = (scnt == SETTLE_LAST);
        tmo_hit     = (tcnt == TIMEOUT_LAST) && !sel_edge;
      end
      ST_SAMPLE:    sample_en = 1'b1;
      ST_WAIT_EDGE: tmo_hit   = (tcnt == TIMEOUT_LAST) && !sel_edge;
      default:      ;
    endcase
  end

  // ---- settle and timeout counters (saturating, never wrap)
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      scnt <= '0;
      tcnt <= '0;
    end else begin
      if (sel_edge || state != ST_SETTLE) scnt <= '0;
      else if (!settle_done)              scnt <= scnt + 1'b1;

      if (sel_edge)                                    tcnt <= '0;
      else if (state != ST_IDLE && tcnt != TIMEOUT_LAST) tcnt <= tcnt + 1'b1;
    end
  end

  // ---- frame assembly
  logic [3:0]     hi_q, lo_q, hi_n, lo_n;
  logic           have_hi, have_lo, have_hi_n, have_lo_n;
  logic [STW-1:0] stable_cnt, stable_n;
  logic [7:0]     prev_frame, frame;
  logic           frame_done;
  logic [7:0]     value_q;
  logic           valid_q, stb_q, bad_q, lost_q;

  always_comb begin
    hi_n      = hi_q;
    lo_n      = lo_q;
    have_hi_n = have_hi;
    have_lo_n = have_lo;
    if (sel_sync[1]) begin
      hi_n      = dec.nib;
      have_hi_n = 1'b1;
    end else begin
      lo_n      = dec.nib;
      have_lo_n = 1'b1;
    end
    frame      = {hi_n, lo_n};
    frame_done = have_hi_n & have_lo_n;
    // stable_cnt == 0 means there is no previous frame to compare against
    if (stable_cnt != '0 && frame == prev_frame)
      stable_n = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
    else
      stable_n = STW'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      have_hi    <= 1'b0;
      have_lo    <= 1'b0;
      stable_cnt <= '0;
      prev_frame <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      stb_q      <= 1'b0;
      bad_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      stb_q  <= 1'b0;
      bad_q  <= 1'b0;
      lost_q <= 1'b0;
      if (tmo_hit) begin
        lost_q     <= 1'b1;
        valid_q    <= 1'b0;
        have_hi    <= 1'b0;
        have_lo    <= 1'b0;
        stable_cnt <= '0;
      end else if (sample_en) begin
        if (!dec.legal) begin
          bad_q      <= 1'b1;
          valid_q    <= 1'b0;
          have_hi    <= 1'b0;
          have_lo    <= 1'b0;
          stable_cnt <= '0;
        end else begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          if (frame_done) begin
            have_hi    <= 1'b0;
            have_lo    <= 1'b0;
            prev_frame <= frame;
            stable_cnt <= stable_n;
            if (stable_n == STABLE_MAX) begin
              value_q <= frame;
              valid_q <= 1'b1;
              stb_q   <= 1'b1;
            end
          end else begin
            have_hi <= have_hi_n;
            have_lo <= have_lo_n;
          end
        end
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = valid_q;
  assign bus.frame_stb   = stb_q;
  assign bus.bad_glyph   = bad_q;
  assign bus.link_lost   = lost_q;

endmodule

// File: tb/tb_ssd_mux_rx.sv
// Directed bench for ssd_mux_rx: an event-queue model predicts every output each
// cycle from sel edges and glyph samples; literal checks pin the headline values.
module tb_ssd_mux_rx;

  localparam int SETTLE  = 20;
  localparam int TIMEOUT = 200;
  localparam int STABLE  = 2;
  localparam int PER     = 50;

`ifdef SSD_RX_SEG_ACTIVE_LOW_EN
  localparam logic [6:0] INV = 7'h7F;
`else
  localparam logic [6:0] INV = 7'h00;
`endif

  localparam logic [6:0] GLYPH [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  ssd_mux_rx_if bus();

  ssd_mux_rx #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .STABLE_FRAMES  (STABLE)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct {
    int         d;     // cycle at which the receiver sees the edge
    logic       sel;
    logic [6:0] seg;   // logical glyph, before any bus inversion
  } edge_t;

  edge_t edges[$];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int n_bad = 0, n_lost = 0, n_stb = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---- behavioural model
  logic [7:0] m_value, m_prev;
  logic       m_vv, m_stb, m_bad, m_lost;
  logic [3:0] m_hi, m_lo;
  bit         m_have_hi, m_have_lo, active;
  int         m_stable, due, last_d;
  edge_t      pend;

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (GLYPH[i] == s) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_value = 8'h00; m_prev = 8'h00; m_vv = 1'b0;
    m_stb = 1'b0; m_bad = 1'b0; m_lost = 1'b0;
    m_hi = 4'h0; m_lo = 4'h0; m_have_hi = 0; m_have_lo = 0;
    m_stable = 0; active = 0; due = -1; last_d = 0;
  endtask

  task automatic m_sample(input edge_t e);
    int v;
    logic [7:0] f;
    v = decode(e.seg);
    if (v < 0) begin
      m_bad = 1'b1; m_vv = 1'b0; m_have_hi = 0; m_have_lo = 0; m_stable = 0;
    end else begin
      if (e.sel) begin m_hi = v[3:0]; m_have_hi = 1; end
      else       begin m_lo = v[3:0]; m_have_lo = 1; end
      if (m_have_hi && m_have_lo) begin
        f = {m_hi, m_lo};
        m_have_hi = 0; m_have_lo = 0;
        m_stable = (m_stable > 0 && f == m_prev) ? ((m_stable < STABLE) ? m_stable + 1 : STABLE) : 1;
        m_prev = f;
        if (m_stable == STABLE) begin m_value = f; m_vv = 1'b1; m_stb = 1'b1; end
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!nrst) begin
        m_reset();
        edges.delete();
        chk("reset_outputs", 32'({bus.value, bus.value_valid, bus.frame_stb, bus.bad_glyph, bus.link_lost}), 32'h0);
      end else begin
        m_stb = 1'b0; m_bad = 1'b0; m_lost = 1'b0;
        if (edges.size() > 0 && edges[0].d == cyc) begin
          pend = edges.pop_front();
          due = cyc + SETTLE + 1;
          last_d = cyc;
          active = 1;
        end else if (due == cyc) begin
          m_sample(pend);
          due = -1;
        end else if (active && cyc == last_d + TIMEOUT) begin
          m_lost = 1'b1; m_vv = 1'b0; m_have_hi = 0; m_have_lo = 0; m_stable = 0;
          active = 0; due = -1;
        end
        chk("value",       32'(bus.value),       32'(m_value));
        chk("value_valid", 32'(bus.value_valid), 32'(m_vv));
        chk("frame_stb",   32'(bus.frame_stb),   32'(m_stb));
        chk("bad_glyph",   32'(bus.bad_glyph),   32'(m_bad));
        chk("link_lost",   32'(bus.link_lost),   32'(m_lost));
        n_bad  += int'(bus.bad_glyph);
        n_lost += int'(bus.link_lost);
        n_stb  += int'(bus.frame_stb);
      end
    end
  end

  // ---- stimulus
  task automatic drive(input logic sel, input logic [6:0] seg);
    edge_t e;
    @(posedge clk); #1;
    if (nrst && sel !== bus.sel_in) begin
      e.d = cyc + 3; e.sel = sel; e.seg = seg;
      edges.push_back(e);
    end
    bus.sel_in = sel;
    bus.seg_in = seg ^ INV;
  endtask

  task automatic show(input logic [3:0] hi, input logic [3:0] lo, input int frames);
    for (int f = 0; f < frames; f++) begin
      drive(1'b1, GLYPH[hi]); repeat (PER - 1) @(posedge clk);
      drive(1'b0, GLYPH[lo]); repeat (PER - 1) @(posedge clk);
    end
  endtask

  initial begin
    int stb_before;
    bus.sel_in = 1'b0;
    bus.seg_in = GLYPH[0] ^ INV;
    repeat (4) @(posedge clk);
    #1;
    chk("t0_value", 32'(bus.value), 32'h00);
    chk("t0_valid", 32'(bus.value_valid), 32'h0);
    nrst = 1'b1;

    // 1: steady 0x3C
    show(4'h3, 4'hC, 3);
    chk("t1_value", 32'(bus.value), 32'h3C);
    chk("t1_valid", 32'(bus.value_valid), 32'h1);

    // 2: 0xFF then wrap to 0x00; one 0x00 frame is not enough
    show(4'hF, 4'hF, 3);
    chk("t2_ff", 32'(bus.value), 32'hFF);
    show(4'h0, 4'h0, 1);
    chk("t2_hold_ff", 32'(bus.value), 32'hFF);
    show(4'h0, 4'h0, 1);
    chk("t2_zero", 32'(bus.value), 32'h00);
    chk("t2_valid", 32'(bus.value_valid), 32'h1);

    // 3: blank glyph on the high digit
    drive(1'b1, 7'h00); repeat (PER - 1) @(posedge clk);
    drive(1'b0, GLYPH[5]); repeat (PER - 1) @(posedge clk);
    chk("t3_invalid", 32'(bus.value_valid), 32'h0);
    chk("t3_held", 32'(bus.value), 32'h00);
    chk("t3_bad_cnt", 32'(n_bad), 32'd1);
    show(4'h5, 4'h5, 2);
    chk("t3_recover", 32'(bus.value), 32'h55);
    chk("t3_valid", 32'(bus.value_valid), 32'h1);

    // 5: sel glitch shorter than the settle time carrying a different glyph
    stb_before = n_stb;
    drive(1'b1, GLYPH[9]); repeat (9) @(posedge clk);
    drive(1'b0, GLYPH[5]); repeat (PER - 1) @(posedge clk);
    chk("t5_no_bad", 32'(n_bad), 32'd1);
    show(4'h5, 4'h5, 1);
    chk("t5_value", 32'(bus.value), 32'h55);
    chk("t5_restb", 32'(n_stb - stb_before), 32'd1);

    // 4: stop toggling -> one link_lost pulse only
    repeat (TIMEOUT + 30) @(posedge clk);
    chk("t4_lost_cnt", 32'(n_lost), 32'd1);
    chk("t4_invalid", 32'(bus.value_valid), 32'h0);
    repeat (2 * TIMEOUT) @(posedge clk);
    chk("t4_single", 32'(n_lost), 32'd1);
    show(4'hA, 4'hB, 2);
    chk("t4_recover", 32'(bus.value), 32'hAB);

    // 6: asynchronous reset mid-settle, then rebuild
    drive(1'b1, GLYPH[1]);
    repeat (7) @(posedge clk);
    #1 nrst = 1'b0;
    #1 chk("t6_async_rst", 32'({bus.value, bus.value_valid, bus.frame_stb, bus.bad_glyph, bus.link_lost}), 32'h0);
    bus.sel_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    show(4'h3, 4'hC, 3);
    chk("t6_value", 32'(bus.value), 32'h3C);
    chk("t6_valid", 32'(bus.value_valid), 32'h1);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
